// File: rtl/sram_frame_writer_if.sv
// rtl/sram_frame_writer_if.sv - byte stream in, SRAM write bus and grant handshake out
interface sram_frame_writer_if #(
    parameter int ADDR_WIDTH = 20
) ();
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  grant;
    logic                  req;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic                  ram_data_oe;
    logic [3:0]            ram_be_n;
    logic                  ram_ce_n;
    logic                  ram_oe_n;
    logic                  ram_we_n;

    modport master (
        input  rx_valid, rx_data, grant,
        output req, ram_addr, ram_wdata, ram_data_oe, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
    );

    modport slave (
        output rx_valid, rx_data, grant,
        input  req, ram_addr, ram_wdata, ram_data_oe, ram_be_n, ram_ce_n, ram_oe_n, ram_we_n
    );
endinterface

// File: rtl/sram_frame_writer.sv
// rtl/sram_frame_writer.sv - packs received bytes into 32-bit words and writes them to base RAM
module sram_frame_writer #(
    parameter int ADDR_WIDTH  = 20,
    parameter int FRAME_WORDS = 120000,
    parameter int WE_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    sram_frame_writer_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] words_written
);
    localparam int WCW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, COLLECT, WAIT_GRANT, SETUP, WRITE, HOLD, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] words_q, words_d;
    logic                  ovf_q, ovf_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           collect_q, collect_d;
    logic [31:0]           pend_word_q, pend_word_d;
    logic                  pend_q, pend_d;
    logic                  restart_q, restart_d;
    logic [ADDR_WIDTH-1:0] restart_base_q, restart_base_d;
    logic [WCW-1:0]        we_cnt_q, we_cnt_d;
    logic                  req_q, req_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  data_oe_q, data_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  we_n_q, we_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic collecting, word_done, consume, do_init;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        words_d        = words_q;
        ovf_d          = ovf_q;
        byte_idx_d     = byte_idx_q;
        collect_d      = collect_q;
        pend_word_d    = pend_word_q;
        pend_d         = pend_q;
        restart_d      = restart_q;
        restart_base_d = restart_base_q;
        we_cnt_d       = we_cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;

        collecting = (state_q != IDLE) && (state_q != DONE);
        word_done  = collecting && bus.rx_valid && (byte_idx_q == 2'd3);
        consume    = (state_q == WAIT_GRANT) && bus.grant;
        do_init    = (state_q inside {IDLE, COLLECT, WAIT_GRANT, DONE}) && (start || restart_q);

        if (collecting && bus.rx_valid) begin
            case (byte_idx_q)
                2'd0:    collect_d[7:0]   = bus.rx_data;
                2'd1:    collect_d[15:8]  = bus.rx_data;
                2'd2:    collect_d[23:16] = bus.rx_data;
                default: collect_d        = collect_q;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
        end

        // The slot being handed to SETUP this cycle counts as free for a word completing now.
        if (word_done) begin
            if (pend_q && !consume) begin
                ovf_d = 1'b1;
            end else begin
                pend_word_d = {bus.rx_data, collect_q};
                pend_d      = 1'b1;
            end
        end else if (consume) begin
            pend_d = 1'b0;
        end

        case (state_q)
            COLLECT: begin
                if (pend_q) state_d = WAIT_GRANT;
            end
            WAIT_GRANT: begin
                if (bus.grant) begin
                    state_d = SETUP;
                    addr_d  = ptr_q;
                    wdata_d = pend_word_q;
                end
            end
            SETUP: begin
                state_d  = WRITE;
                we_cnt_d = '0;
            end
            WRITE: begin
                if (we_cnt_q == WCW'(WE_CYCLES - 1)) state_d = HOLD;
                else we_cnt_d = we_cnt_q + 1'b1;
            end
            HOLD: begin
                ptr_d   = ptr_q + 1'b1;
                words_d = words_q + 1'b1;
                // A latched restart gets one COLLECT cycle so the completed count is visible.
                if (restart_q) state_d = COLLECT;
                else if (words_d == ADDR_WIDTH'(FRAME_WORDS)) state_d = DONE;
                else if (pend_q) state_d = WAIT_GRANT;
                else state_d = COLLECT;
            end
            default: state_d = state_q;
        endcase

        if ((state_q inside {SETUP, WRITE, HOLD}) && start) begin
            restart_d      = 1'b1;
            restart_base_d = base_addr;
        end

        if (do_init) begin
            state_d    = COLLECT;
            ptr_d      = start ? base_addr : restart_base_q;
            words_d    = '0;
            ovf_d      = 1'b0;
            byte_idx_d = 2'd0;
            pend_d     = 1'b0;
            restart_d  = 1'b0;
        end

        req_d     = state_d inside {WAIT_GRANT, SETUP, WRITE, HOLD};
        data_oe_d = state_d inside {SETUP, WRITE, HOLD};
        ce_n_d    = !(state_d inside {SETUP, WRITE, HOLD});
        we_n_d    = (state_d != WRITE);
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            words_q        <= '0;
            ovf_q          <= 1'b0;
            byte_idx_q     <= 2'd0;
            collect_q      <= '0;
            pend_word_q    <= '0;
            pend_q         <= 1'b0;
            restart_q      <= 1'b0;
            restart_base_q <= '0;
            we_cnt_q       <= '0;
            req_q          <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            data_oe_q      <= 1'b0;
            ce_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            words_q        <= words_d;
            ovf_q          <= ovf_d;
            byte_idx_q     <= byte_idx_d;
            collect_q      <= collect_d;
            pend_word_q    <= pend_word_d;
            pend_q         <= pend_d;
            restart_q      <= restart_d;
            restart_base_q <= restart_base_d;
            we_cnt_q       <= we_cnt_d;
            req_q          <= req_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            data_oe_q      <= data_oe_d;
            ce_n_q         <= ce_n_d;
            we_n_q         <= we_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.req         = req_q;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.ram_data_oe = data_oe_q;
    assign bus.ram_be_n    = 4'b0000;
    assign bus.ram_ce_n    = ce_n_q;
    assign bus.ram_oe_n    = 1'b1;
    assign bus.ram_we_n    = we_n_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign overflow        = ovf_q;
    assign words_written   = words_q;
endmodule

// File: tb/tb_sram_frame_writer.sv
// tb/tb_sram_frame_writer.sv - directed and random-data checks of sram_frame_writer against a word-level model
module tb_sram_frame_writer;
    localparam int AW = 20;
    localparam int FW = 3;
    localparam int WE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          busy, done, overflow;
    logic [AW-1:0] words_written;

    sram_frame_writer_if #(.ADDR_WIDTH(AW)) bus ();

    sram_frame_writer #(.ADDR_WIDTH(AW), .FRAME_WORDS(FW), .WE_CYCLES(WE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .bus(bus),
        .busy(busy), .done(done), .overflow(overflow), .words_written(words_written)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Bus monitor: one entry per completed write strobe.
    int            we_len = 0;
    int            proto_err = 0;
    logic [AW-1:0] cap_addr;
    logic [31:0]   cap_data;
    logic [AW-1:0] mon_addr[$];
    logic [31:0]   mon_data[$];
    int            mon_len[$];

    always @(negedge clk) begin
        if (bus.ram_we_n === 1'b0) begin
            if (we_len == 0) begin
                cap_addr = bus.ram_addr;
                cap_data = bus.ram_wdata;
            end
            we_len++;
            if (bus.ram_ce_n !== 1'b0 || bus.ram_data_oe !== 1'b1 || bus.req !== 1'b1) proto_err++;
        end else if (we_len != 0) begin
            mon_addr.push_back(cap_addr);
            mon_data.push_back(cap_data);
            mon_len.push_back(we_len);
            we_len = 0;
        end
    end

    // Word-level reference model.
    int            mb[$];
    logic [AW-1:0] m_ptr;
    int            m_words;
    bit            m_active = 0;
    bit            m_slot_full = 0;
    bit            m_hold = 0;
    bit            m_ovf = 0;
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_start(input logic [AW-1:0] b);
        mb.delete();
        m_ptr = b;
        m_words = 0;
        m_active = 1;
        m_slot_full = 0;
        m_ovf = 0;
    endtask

    task automatic model_byte(input int b);
        logic [31:0] w;
        if (!m_active) return;
        mb.push_back(b);
        if (mb.size() == 4) begin
            w = mb[0] + mb[1] * 256 + mb[2] * 65536 + mb[3] * 16777216;
            mb.delete();
            if (m_slot_full) begin
                m_ovf = 1;
            end else begin
                exp_addr.push_back(m_ptr);
                exp_data.push_back(w);
                m_ptr = AW'((longint'(m_ptr) + 1) % (longint'(1) << AW));
                m_slot_full = m_hold;
                m_words++;
                if (m_words == FW) m_active = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        model_byte(b);
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b);
        base_addr = b;
        start = 1'b1;
        model_start(b);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 200; i++) begin
            if (mon_addr.size() >= n) break;
            tick();
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        chk({tag, "_count"}, mon_addr.size(), exp_addr.size());
        n = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, mon_addr[i], exp_addr[i]);
            chk({tag, "_data"}, mon_data[i], exp_data[i]);
            chk({tag, "_we_len"}, mon_len[i], WE);
        end
        mon_addr.delete(); mon_data.delete(); mon_len.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        int lat;
        bit ok;
        bit saw1;
        bit cleared;
        logic [AW-1:0] b1, b2;

        rst_n = 1'b0; start = 1'b0; base_addr = '0;
        bus.rx_valid = 1'b0; bus.rx_data = '0; bus.grant = 1'b0;
        repeat (3) tick();
        chk("rst_ce_n", bus.ram_ce_n, 1);
        chk("rst_we_n", bus.ram_we_n, 1);
        chk("rst_oe_n", bus.ram_oe_n, 1);
        chk("rst_data_oe", bus.ram_data_oe, 0);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_wdata", bus.ram_wdata, 0);
        chk("rst_be_n", bus.ram_be_n, 0);
        chk("rst_flags", {bus.req, busy, done, overflow}, 0);
        chk("rst_words", words_written, 0);
        rst_n = 1'b1;
        tick();

        // Bytes in IDLE are ignored.
        bus.grant = 1'b1;
        repeat (8) send_byte(8'($urandom_range(0, 255)));
        repeat (6) tick();
        chk("idle_writes", mon_addr.size(), 0);
        chk("idle_busy", busy, 0);

        // Single word with grant held; ce_n falls 3 clocks after the 4th byte's cycle begins.
        pulse_start(20'h00100);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.ram_ce_n === 1'b0) break;
            tick();
            lat++;
        end
        chk("ce_latency", lat, 2);
        wait_writes(1);
        tick();
        chk("t1_data_const", mon_data.size() > 0 ? mon_data[0] : 32'h0, 32'h44332211);
        compare_writes("t1");
        chk("t1_words", words_written, 1);
        chk("t1_req_busy", {bus.req, busy, bus.ram_ce_n}, 3'b011);

        // Grant withheld: request stays up with the bus released.
        bus.grant = 1'b0;
        repeat (4) send_byte(8'($urandom_range(0, 255)));
        ok = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.req !== 1'b1 || bus.ram_ce_n !== 1'b1) ok = 0;
        end
        chk("t2_wait_bus", ok, 1);
        bus.grant = 1'b1;
        tick();
        chk("t2_ce_after_grant", bus.ram_ce_n, 0);
        wait_writes(1);
        tick();
        compare_writes("t2");
        chk("t2_words", words_written, 2);

        // Overflow: second word completes while the first is still pending.
        pulse_start(AW'($urandom_range(0, 1 << AW - 1)));
        bus.grant = 1'b0; m_hold = 1;
        repeat (4) send_byte(8'($urandom_range(0, 255)));
        repeat (3) tick();
        chk("t3_no_ovf_yet", overflow, 0);
        repeat (4) send_byte(8'($urandom_range(0, 255)));
        tick();
        chk("t3_ovf", overflow, m_ovf);
        bus.grant = 1'b1; m_hold = 0; m_slot_full = 0;
        wait_writes(1);
        repeat (6) tick();
        compare_writes("t3");
        chk("t3_words", words_written, 1);
        chk("t3_ovf_sticky", overflow, 1);

        // Full frame with address wrap, then bytes in DONE are ignored.
        pulse_start(20'hFFFFF);
        chk("t4_ovf_cleared", overflow, 0);
        for (int i = 0; i < 12; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_writes(3);
        repeat (3) tick();
        compare_writes("t4");
        chk("t4_done", {done, busy, bus.req}, 3'b100);
        chk("t4_words", words_written, 3);
        send_byte(8'($urandom_range(0, 255)));
        repeat (8) tick();
        chk("t4_done_quiet", {mon_addr.size() == 0, bus.ram_ce_n, done}, 3'b111);

        // start during WRITE: cycle completes and counts, then re-init to new base.
        b1 = AW'($urandom_range(0, 1 << AW - 1));
        b2 = AW'($urandom_range(0, 1 << AW - 1));
        pulse_start(b1);
        repeat (4) send_byte(8'($urandom_range(0, 255)));
        ok = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.ram_we_n === 1'b0) begin ok = 1; break; end
            tick();
        end
        chk("t5_reached_write", ok, 1);
        base_addr = b2;
        start = 1'b1;
        tick();
        start = 1'b0;
        model_start(b2);
        saw1 = 0; cleared = 0;
        for (int k = 0; k < 30; k++) begin
            if (words_written === 1) saw1 = 1;
            if (saw1 && words_written === 0) begin cleared = 1; break; end
            tick();
        end
        chk("t5_counted", saw1, 1);
        chk("t5_cleared", cleared, 1);
        repeat (4) send_byte(8'($urandom_range(0, 255)));
        wait_writes(2);
        repeat (3) tick();
        compare_writes("t5");

        // Async reset in the middle of a write strobe.
        repeat (4) send_byte(8'($urandom_range(0, 255)));
        for (int k = 0; k < 30; k++) begin
            if (bus.ram_we_n === 1'b0) break;
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_ce_we", {bus.ram_ce_n, bus.ram_we_n}, 2'b11);
        chk("t6_async_words", words_written, 0);
        tick();
        rst_n = 1'b1;
        tick();
        mon_addr.delete(); mon_data.delete(); mon_len.delete();
        exp_addr.delete(); exp_data.delete();
        chk("t6_idle", {busy, bus.req, bus.ram_data_oe}, 0);

        chk("protocol", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
